pio_in_edgecap: RTL

- Parametrised successor to the core's plain input PIO slave.
- Adds configurable width, a metastability synchroniser and optional per-bit debounce.
- Adds edge capture with write-1-to-clear, a per-bit interrupt mask and a level IRQ output.
- Sits on the Avalon-MM system bus as a slave; typical uses are DIP switches, push-buttons and external status lines.

---
 rtl/pio_in_edgecap_pkg.sv | 24 ++
 rtl/pio_in_bit_filter.sv | 79 +++++++
 rtl/pio_in_edgecap.sv | 95 +++++++++
 3 files changed

// File: rtl/pio_in_edgecap_pkg.sv
// Shared constants and helpers for the edge-capturing input PIO slave.
package pio_in_edgecap_pkg;

    // Word addresses of the slave registers; address 1 is reserved.
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Edge type captured into EDGECAP.
    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_BOTH = 2;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pio_in_bit_filter.sv
// Per-bit input conditioning: synchroniser, optional debounce and edge detection.
module pio_in_bit_filter
    import pio_in_edgecap_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 0,
    parameter int unsigned EDGE_MODE       = EDGE_RISE
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_bit,
    output logic deb,
    output logic edge_evt
);

    // Counter is kept one bit wide when the filter is bypassed so the vector stays legal.
    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 0) ? clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntLast =
        CntW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   deb_q, deb_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   s;
    logic                   rise, fall;

    assign s = sync_q[SYNC_STAGES-1];

    // Shift the raw input into the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_bit};
    end

    // Accept a new level only after it has been stable for DEBOUNCE_CYCLES cycles.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (DEBOUNCE_CYCLES == 0) begin
            deb_d = s;
            cnt_d = '0;
        end else if (s == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            deb_d = s;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Event fires on the cycle deb is about to change in the selected direction.
    always_comb begin
        rise = deb_d & ~deb_q;
        fall = ~deb_d & deb_q;
        if (EDGE_MODE == EDGE_BOTH) begin
            edge_evt = rise | fall;
        end else if (EDGE_MODE == EDGE_FALL) begin
            edge_evt = fall;
        end else begin
            edge_evt = rise;
        end
    end

    // Filter state; reset discards any pending debounce count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            deb_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
        end
    end

    assign deb = deb_q;

endmodule

// File: rtl/pio_in_edgecap.sv
// Avalon-MM input PIO slave with synchroniser, debounce, edge capture and level IRQ.
module pio_in_edgecap
    import pio_in_edgecap_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 10,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 0,
    parameter int unsigned EDGE_MODE       = EDGE_RISE
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] deb;
    logic [DATA_WIDTH-1:0] evt;
    logic [DATA_WIDTH-1:0] irqmask_q, irqmask_d;
    logic [DATA_WIDTH-1:0] edgecap_q, edgecap_d;
    logic [DATA_WIDTH-1:0] clr;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic [31:0]           readdata_q, readdata_d;
    logic                  irq_q, irq_d;
    logic                  wr_en;
    logic                  unused_wdata;

    // Upper write-data bits have no destination when DATA_WIDTH < 32.
    assign unused_wdata = ^writedata;

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
        pio_in_bit_filter #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .EDGE_MODE       (EDGE_MODE)
        ) u_filter (
            .clk      (clk),
            .reset_n  (reset_n),
            .in_bit   (in_port[i]),
            .deb      (deb[i]),
            .edge_evt (evt[i])
        );
    end

    assign wr_en = chipselect & ~write_n;

    // Register writes; a capture event beats a same-cycle clear.
    always_comb begin
        irqmask_d = irqmask_q;
        clr       = '0;
        if (wr_en && (address == ADDR_IRQMASK)) begin
            irqmask_d = writedata[DATA_WIDTH-1:0];
        end
        if (wr_en && (address == ADDR_EDGECAP)) begin
            clr = writedata[DATA_WIDTH-1:0];
        end
        edgecap_d = (edgecap_q & ~clr) | evt;
        irq_d     = |(edgecap_d & irqmask_d);
    end

    // Read mux on current state, registered every cycle regardless of chipselect.
    always_comb begin
        rd_mux = '0;
        unique case (address)
            ADDR_DATA:    rd_mux = deb;
            ADDR_IRQMASK: rd_mux = irqmask_q;
            ADDR_EDGECAP: rd_mux = edgecap_q;
            default:      rd_mux = '0;
        endcase
        readdata_d = 32'(rd_mux);
    end

    // Register file, read data and interrupt flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
